// File: rtl/mesh_router_vc_if.sv
// ---------------------------------------------------------------------------
// mesh_router_vc_if
// Bundles the per-port send/ready/packet signals of the five-port virtual
// channel mesh router. Port p uses bit [p] of each flag vector and bits
// [p*DATA_WIDTH +: DATA_WIDTH] of each packet vector (0=cw, 1=ccw, 2=ns,
// 3=sn, 4=pe).
//   si   : per-input send from the upstream neighbour
//   di   : per-input packet
//   ri   : per-input ready back to the upstream neighbour
//   ro   : per-output ready from the downstream neighbour
//   so   : per-output send to the downstream neighbour
//   dout : per-output packet ("do" is a reserved word, hence the name)
// Modports: slave = router side, master = environment side.
// ---------------------------------------------------------------------------
interface mesh_router_vc_if #(
    parameter int DATA_WIDTH = 64
);
    localparam int NUM_PORTS = 5;

    logic [NUM_PORTS-1:0]            si;
    logic [NUM_PORTS*DATA_WIDTH-1:0] di;
    logic [NUM_PORTS-1:0]            ri;
    logic [NUM_PORTS-1:0]            ro;
    logic [NUM_PORTS-1:0]            so;
    logic [NUM_PORTS*DATA_WIDTH-1:0] dout;

    modport master (output si, di, ro, input  ri, so, dout);
    modport slave  (input  si, di, ro, output ri, so, dout);
endinterface

// File: rtl/mesh_router_vc.sv
// ---------------------------------------------------------------------------
// mesh_router_vc
// Five-port mesh router with two virtual channels per input and per output.
// A global polarity bit P alternates every cycle: external traffic (accept
// and send) uses VC P while the switch moves packets from input to output
// buffers on VC ~P, so the two never touch the same single-entry buffer.
// Routing is X-first, then Y, then eject to the PE; the consumed hop field
// is decremented. Each output has a round-robin arbiter over the inputs.
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous, active-high
//   polarity_out : current polarity P
//   bus          : mesh_router_vc_if.slave (si, di, ri, ro, so, dout)
// ---------------------------------------------------------------------------
module mesh_router_vc #(
    parameter int DATA_WIDTH = 64,
    parameter int HOP_WIDTH  = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            polarity_out,
    mesh_router_vc_if.slave bus
);
    localparam int NUM_PORTS = 5;
    localparam int DW        = DATA_WIDTH;
    localparam int YHI       = DW - 9;
    localparam int XHI       = DW - 9 - HOP_WIDTH;

    typedef logic [DW-1:0] pkt_t;

    logic                   pol;
    logic                   rd_vc;
    logic [1:0]             in_vld_p0  [NUM_PORTS];
    pkt_t                   in_buf_p0  [NUM_PORTS][2];
    logic [1:0]             out_vld_p1 [NUM_PORTS];
    pkt_t                   out_buf_p1 [NUM_PORTS][2];
    logic [2:0]             rr_ptr     [NUM_PORTS];
    logic [2:0]             req_port   [NUM_PORTS];
    pkt_t                   hop_pkt    [NUM_PORTS];
    logic [NUM_PORTS-1:0]   gnt_vld;
    logic [2:0]             gnt_idx    [NUM_PORTS];
    logic [NUM_PORTS-1:0]   acc;
    logic [NUM_PORTS-1:0]   send;

    // Saturating hop decrement: a zero hop count stays zero.
    function automatic logic [HOP_WIDTH-1:0] hop_dec(input logic [HOP_WIDTH-1:0] h);
        return (h == '0) ? '0 : h - 1'b1;
    endfunction

    // Output port chosen for a packet: X first (EW picks cw/ccw), then Y
    // (NS picks ns/sn), otherwise eject to the PE.
    function automatic logic [2:0] route_port(input pkt_t p);
        logic [HOP_WIDTH-1:0] xh;
        logic [HOP_WIDTH-1:0] yh;
        xh = p[XHI -: HOP_WIDTH];
        yh = p[YHI -: HOP_WIDTH];
        if (xh != '0)
            return p[DW-3] ? 3'd0 : 3'd1;
        else if (yh != '0)
            return p[DW-2] ? 3'd3 : 3'd2;
        else
            return 3'd4;
    endfunction

    // Header rewrite matching route_port: only the consumed hop field moves.
    function automatic pkt_t route_hdr(input pkt_t p);
        pkt_t                 r;
        logic [HOP_WIDTH-1:0] xh;
        logic [HOP_WIDTH-1:0] yh;
        r  = p;
        xh = p[XHI -: HOP_WIDTH];
        yh = p[YHI -: HOP_WIDTH];
        if (xh != '0)
            r[XHI -: HOP_WIDTH] = hop_dec(xh);
        else if (yh != '0)
            r[YHI -: HOP_WIDTH] = hop_dec(yh);
        return r;
    endfunction

    assign rd_vc        = ~pol;
    assign polarity_out = pol;
    assign acc          = bus.si & bus.ri;

    always_comb begin
        bus.ri = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            bus.ri[p] = ~in_vld_p0[p][pol];
    end

    // ---- stage p0 -> p1: route and switch allocation on VC ~P ----
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            req_port[p] = route_port(in_buf_p0[p][rd_vc]);
            hop_pkt[p]  = route_hdr(in_buf_p0[p][rd_vc]);
        end
    end

    always_comb begin
        logic [3:0] sum;
        logic       found;
        logic [2:0] win;
        sum = '0;
        for (int q = 0; q < NUM_PORTS; q++) begin
            found = 1'b0;
            win   = '0;
            if (!out_vld_p1[q][rd_vc]) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    sum = {1'b0, rr_ptr[q]} + 4'(k);
                    if (sum >= 4'd5)
                        sum = sum - 4'd5;
                    if (!found && in_vld_p0[sum[2:0]][rd_vc] &&
                        req_port[sum[2:0]] == 3'(q)) begin
                        found = 1'b1;
                        win   = sum[2:0];
                    end
                end
            end
            gnt_vld[q] = found;
            gnt_idx[q] = win;
        end
    end

    // Control state: polarity, valid bits and arbiter pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pol <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                in_vld_p0[p]  <= '0;
                out_vld_p1[p] <= '0;
                rr_ptr[p]     <= '0;
            end
        end else begin
            pol <= ~pol;
            for (int p = 0; p < NUM_PORTS; p++)
                if (acc[p])
                    in_vld_p0[p][pol] <= 1'b1;
            for (int q = 0; q < NUM_PORTS; q++) begin
                if (send[q])
                    out_vld_p1[q][pol] <= 1'b0;
                if (gnt_vld[q]) begin
                    out_vld_p1[q][rd_vc]         <= 1'b1;
                    in_vld_p0[gnt_idx[q]][rd_vc] <= 1'b0;
                    rr_ptr[q] <= (gnt_idx[q] == 3'd4) ? 3'd0 : gnt_idx[q] + 3'd1;
                end
            end
        end
    end

    // Packet storage; the stored VC bit is forced to the accepting polarity.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++)
            if (acc[p])
                in_buf_p0[p][pol] <= {pol, bus.di[p*DW +: DW-1]};
        for (int q = 0; q < NUM_PORTS; q++)
            if (gnt_vld[q])
                out_buf_p1[q][rd_vc] <= hop_pkt[gnt_idx[q]];
    end

    // ---- stage p1 -> output: send on VC P ----
    // Sends are held off while reset is asserted so nothing leaks out
    // during the reset cycle itself.
    always_comb begin
        send = '0;
        for (int q = 0; q < NUM_PORTS; q++)
            send[q] = out_vld_p1[q][pol] & bus.ro[q] & ~reset;
    end

    assign bus.so = send;

    always_comb begin
        bus.dout = '0;
        for (int q = 0; q < NUM_PORTS; q++)
            if (send[q])
                bus.dout[q*DW +: DW] = out_buf_p1[q][pol];
    end
endmodule

// File: tb/tb_mesh_router_vc.sv
// ---------------------------------------------------------------------------
// tb_mesh_router_vc
// Directed bench for mesh_router_vc. Inputs change 1 time unit after each
// rising edge, outputs are sampled on the falling edge. tb_pol tracks the
// expected router polarity from the bench side.
// ---------------------------------------------------------------------------
module tb_mesh_router_vc;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic reset;
    logic polarity_out;
    logic tb_pol;
    int   n_chk = 0;
    int   n_err = 0;

    mesh_router_vc_if #(.DATA_WIDTH(DW)) bus ();

    mesh_router_vc #(.DATA_WIDTH(DW), .HOP_WIDTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .polarity_out (polarity_out),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic vc, input logic ns, input logic ew,
                                         input logic [3:0] yh, input logic [3:0] xh,
                                         input logic [47:0] pay);
        logic [DW-1:0] r;
        r        = '0;
        r[63]    = vc;
        r[62]    = ns;
        r[61]    = ew;
        r[60:56] = 5'b10110;
        r[55:52] = yh;
        r[51:48] = xh;
        r[47:0]  = pay;
        return r;
    endfunction

    function automatic logic [319:0] slot(input int q, input logic [DW-1:0] p);
        logic [319:0] r;
        r = '0;
        r[q*DW +: DW] = p;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        tb_pol = ~tb_pol;
        bus.si = '0;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic put(input int p, input logic [DW-1:0] pk);
        bus.si[p]          = 1'b1;
        bus.di[p*DW +: DW] = pk;
    endtask

    // One idle cycle then a delivery on the pe output.
    task automatic pe_out(input string tag, input logic [DW-1:0] exp);
        cyc(); neg();
        chk({tag, "_gap"}, 320'(bus.so), 320'(0));
        cyc(); neg();
        chk({tag, "_so"}, 320'(bus.so), 320'(5'b10000));
        chk({tag, "_do"}, bus.dout, slot(4, exp));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1);
    end

    initial begin
        logic          v;
        logic          va;
        logic [DW-1:0] zexp;

        reset  = 1'b1;
        tb_pol = 1'b0;
        bus.si = '0;
        bus.di = '0;
        bus.ro = 5'h1f;

        // Reset held over two rising edges.
        neg();
        chk("rst_so", 320'(bus.so), 320'(0));
        chk("rst_do", bus.dout, 320'(0));
        @(posedge clk); #1;
        reset  = 1'b0;
        tb_pol = 1'b0;

        // cw injection: EW=1, XHOP=2 -> cw with XHOP=1, VC forced to 0.
        put(0, mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd2, 48'h1234_5678_9abc));
        neg();
        chk("post_rst_pol", 320'(polarity_out), 320'(0));
        chk("post_rst_ri", 320'(bus.ri), 320'(5'h1f));
        chk("post_rst_so", 320'(bus.so), 320'(0));
        cyc(); neg();
        chk("pol_toggle", 320'(polarity_out), 320'(tb_pol));
        chk("cw_gap", 320'(bus.so), 320'(0));
        cyc(); neg();
        chk("cw_so", 320'(bus.so), 320'(5'b00001));
        chk("cw_do", bus.dout, slot(0, mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 48'h1234_5678_9abc)));

        // pe -> ns: YHOP=3, NS=0 -> ns with YHOP=2.
        cyc(); v = tb_pol;
        put(4, mk(1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 48'h0000_cafe_0001));
        neg();
        chk("cw_clear", 320'(bus.so), 320'(0));
        cyc(); neg();
        chk("ns_gap", 320'(bus.so), 320'(0));
        cyc(); neg();
        chk("ns_so", 320'(bus.so), 320'(5'b00100));
        chk("ns_do", bus.dout, slot(2, mk(v, 1'b0, 1'b0, 4'd2, 4'd0, 48'h0000_cafe_0001)));

        // Re-inject with no hops left: ejects to pe unchanged.
        v = tb_pol;
        put(4, mk(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 48'h0000_cafe_0002));
        pe_out("eject", mk(v, 1'b1, 1'b1, 4'd0, 4'd0, 48'h0000_cafe_0002));

        // Round-robin: cw, ccw, ns contend for pe on one VC -> 0, 1, 2.
        cyc(); v = tb_pol;
        put(0, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 48'ha3));
        put(1, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 48'hb3));
        put(2, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 48'hc3));
        neg();
        chk("rr_ri", 320'(bus.ri), 320'(5'h1f));
        pe_out("rr_cw",  mk(v, 1'b0, 1'b0, 4'd0, 4'd0, 48'ha3));
        pe_out("rr_ccw", mk(v, 1'b0, 1'b0, 4'd0, 4'd0, 48'hb3));
        pe_out("rr_ns",  mk(v, 1'b0, 1'b0, 4'd0, 4'd0, 48'hc3));

        // Pointer now at 3: pe wins, then it wraps to cw, then ccw.
        cyc(); v = tb_pol;
        put(0, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 48'hd3));
        put(1, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 48'he3));
        put(4, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 48'hf3));
        pe_out("wrap_pe",  mk(v, 1'b0, 1'b0, 4'd0, 4'd0, 48'hf3));
        pe_out("wrap_cw",  mk(v, 1'b0, 1'b0, 4'd0, 4'd0, 48'hd3));
        pe_out("wrap_ccw", mk(v, 1'b0, 1'b0, 4'd0, 4'd0, 48'he3));

        // Backpressure on pe: D and E fill both pe output VCs, F waits in
        // cw's VC-va input buffer, so only that VC's ready drops.
        cyc(); va = tb_pol;
        bus.ro = 5'b01111;
        put(0, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 48'hd4));
        neg();
        chk("bp_ri_d", 320'(bus.ri), 320'(5'h1f));
        cyc();
        put(0, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 48'he4));
        neg();
        chk("bp_ri_e", 320'(bus.ri), 320'(5'h1f));
        cyc();
        put(0, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 48'hf4));
        neg();
        chk("bp_ri_f", 320'(bus.ri), 320'(5'h1f));
        for (int i = 0; i < 7; i++) begin
            cyc(); neg();
            chk("bp_so", 320'(bus.so), 320'(0));
            chk("bp_ri", 320'(bus.ri), 320'((tb_pol == va) ? 5'h1e : 5'h1f));
        end
        cyc();
        bus.ro = 5'h1f;
        neg();
        chk("bp_d_so", 320'(bus.so), 320'(5'b10000));
        chk("bp_d_do", bus.dout, slot(4, mk(va, 1'b0, 1'b0, 4'd0, 4'd0, 48'hd4)));
        cyc(); neg();
        chk("bp_e_so", 320'(bus.so), 320'(5'b10000));
        chk("bp_e_do", bus.dout, slot(4, mk(~va, 1'b0, 1'b0, 4'd0, 4'd0, 48'he4)));
        cyc(); neg();
        chk("bp_f_so", 320'(bus.so), 320'(5'b10000));
        chk("bp_f_do", bus.dout, slot(4, mk(va, 1'b0, 1'b0, 4'd0, 4'd0, 48'hf4)));
        chk("bp_ri_rel", 320'(bus.ri), 320'(5'h1f));
        cyc(); neg();
        chk("bp_drained", 320'(bus.so), 320'(0));

        // Reset with three packets in flight.
        cyc();
        bus.ro = 5'b00000;
        put(0, mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 48'h51));
        put(1, mk(1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 48'h52));
        put(2, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 48'h53));
        cyc(); cyc(); neg();
        chk("mid_held", 320'(bus.so), 320'(0));
        cyc();
        reset  = 1'b1;
        bus.ro = 5'h1f;
        neg();
        chk("mid_rst_so", 320'(bus.so), 320'(0));
        chk("mid_rst_do", bus.dout, 320'(0));
        cyc();
        reset  = 1'b0;
        tb_pol = 1'b0;
        neg();
        chk("mid_pol", 320'(polarity_out), 320'(0));
        chk("mid_ri", 320'(bus.ri), 320'(5'h1f));
        chk("mid_so", 320'(bus.so), 320'(0));
        for (int i = 0; i < 5; i++) begin
            cyc(); neg();
            chk("mid_quiet", 320'(bus.so), 320'(0));
            chk("mid_pol_run", 320'(polarity_out), 320'(tb_pol));
        end

        // All-zero packet on pe is still a real packet.
        cyc();
        zexp     = '0;
        zexp[63] = tb_pol;
        put(4, '0);
        pe_out("zero", zexp);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
